// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  localparam logic [3:0] MAX_S    = 4'(MAX_STREAK);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = data port owns the access
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        data_wins;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    data_wins  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          data_wins = d_req && !(if_req && (streak_q == MAX_S));
          owner_d   = data_wins;
          we_d      = data_wins & d_we;
          addr_d    = data_wins ? d_addr : if_addr;
          wdata_d   = data_wins ? d_wdata : '0;
          // A data win with fetch waiting implies streak_q < MAX_S, so +1 saturates naturally
          if (data_wins && if_req) streak_d = streak_q + 4'd1;
          else                     streak_d = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q) d_rdata_d  = mem_rdata;
          else         if_rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) & ~owner_q;
  assign d_ack     = (state_q == RESP) & owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int L  = 2;
  localparam int MS = 4;
  localparam int L1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall;

  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_stall;

  mem_port_arbiter #(.LATENCY(L), .MAX_STREAK(MS)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_port_arbiter #(.LATENCY(L1), .MAX_STREAK(MS)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall(b_stall)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          lat;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vt[6];

  // random-test transaction model
  logic [31:0] mref[16];
  logic [31:0] e_if, e_d, tx_addr, tx_wdata, tx_rdata;
  logic        tx_valid, tx_d, tx_we, e_en, e_ifack, e_dack;
  logic [3:0]  idx;
  int          tx_i, free_at, streak, ack_c, nack;

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h8C220004, L + 2, 32'h8C220004, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        2,     32'h8C220004, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h12345678, L + 2, 32'h8C220004, 32'h12345678};
    vt[3] = '{1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 32'h0,        2,     32'h8C220004, 32'h12345678};
    vt[4] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'hFFFFFFFF, L + 2, 32'hFFFFFFFF, 32'h12345678};
    vt[5] = '{1'b1, 1'b0, 32'h3,   32'h0,        32'hA5A5A5A5, L + 2, 32'hFFFFFFFF, 32'hA5A5A5A5};

    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h80; d_addr = 32'h200; d_wdata = 32'h11; mem_rdata = '0;
    b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;

    // reset held with both requests pending
    #2 reset = 1'b0;
    step(); step();
    #1;
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_stall", stall, 1'b1);

    // release: data wins first, then the streak guard pattern repeats
    reset = 1'b1;
    step();
    chk1("rel_mem_en", mem_en, 1'b1);
    chk1("rel_mem_we", mem_we, 1'b1);
    chk("rel_mem_addr", mem_addr, 32'h200);
    chk("rel_mem_wdata", mem_wdata, 32'h11);
    nack = 0;
    for (int k = 0; k < 200 && nack < 10; k++) begin
      step();
      chk1("streak_dual_ack", if_ack & d_ack, 1'b0);
      if (if_ack || d_ack) begin
        chk1("streak_order_is_fetch", if_ack, (nack % (MS + 1)) == MS);
        nack++;
      end
    end
    chk("streak_ack_count", nack, 10);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();

    // isolated single transactions
    for (int v = 0; v < 6; v++) begin
      logic got;
      got = 1'b0;
      if (vt[v].is_d) begin
        d_req = 1'b1; d_we = vt[v].we; d_addr = vt[v].addr; d_wdata = vt[v].wdata;
      end else begin
        if_req = 1'b1; if_addr = vt[v].addr;
      end
      for (int k = 1; k <= 12 && !got; k++) begin
        step();
        mem_rdata = (k == L + 1) ? vt[v].mdata : $urandom;
        chk1("tbl_mem_en", mem_en, k == 1);
        if (k == 1) begin
          chk("tbl_mem_addr", mem_addr, vt[v].addr);
          chk1("tbl_mem_we", mem_we, vt[v].we);
          if (vt[v].we) chk("tbl_mem_wdata", mem_wdata, vt[v].wdata);
        end
        chk1("tbl_other_ack", vt[v].is_d ? if_ack : d_ack, 1'b0);
        if (vt[v].is_d ? d_ack : if_ack) begin
          got = 1'b1;
          chk("tbl_latency", k, vt[v].lat);
          if_req = 1'b0; d_req = 1'b0;
        end
      end
      chk1("tbl_ack_seen", got, 1'b1);
      chk("tbl_if_rdata", if_rdata, vt[v].exp_if);
      chk("tbl_d_rdata", d_rdata, vt[v].exp_d);
      step();
    end

    // data req dropped during WAIT still completes exactly once
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; nack = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      mem_rdata = (k == L + 1) ? 32'h0BADCAFE : $urandom;
      if (k == 2) d_req = 1'b0;
      if (d_ack) begin
        nack++;
        chk("drop_ack_cycle", k, L + 2);
      end
    end
    chk("drop_ack_count", nack, 1);
    chk("drop_d_rdata", d_rdata, 32'h0BADCAFE);

    // reset asserted in WAIT
    d_req = 1'b1; d_addr = 32'h24;
    step(); step();
    reset = 1'b0;
    #1;
    chk1("mr_mem_en", mem_en, 1'b0);
    chk1("mr_if_ack", if_ack, 1'b0);
    chk1("mr_d_ack", d_ack, 1'b0);
    chk("mr_if_rdata", if_rdata, 32'h0);
    chk("mr_d_rdata", d_rdata, 32'h0);
    chk("mr_mem_addr", mem_addr, 32'h0);
    chk1("mr_stall", stall, 1'b1);
    d_req = 1'b0;
    step();
    reset = 1'b1;
    nack = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      mem_rdata = $urandom;
      if (if_ack || d_ack || mem_en) nack++;
    end
    chk("mr_no_activity", nack, 0);

    // LATENCY=1 instance: fetch then data read
    for (int p = 0; p < 2; p++) begin
      logic [31:0] md;
      md = 32'h10000000 + 32'(p);
      nack = 0;
      if (p == 0) begin b_if_req = 1'b1; b_if_addr = 32'h50; end
      else begin b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h54; end
      for (int k = 1; k <= 8; k++) begin
        step();
        b_mem_rdata = (k == L1 + 1) ? md : $urandom;
        if (k == 1) chk1("l1_mem_en", b_mem_en, 1'b1);
        if (p == 0 ? b_if_ack : b_d_ack) begin
          nack++;
          chk("l1_ack_cycle", k, L1 + 2);
          b_if_req = 1'b0; b_d_req = 1'b0;
        end
      end
      chk("l1_ack_count", nack, 1);
      chk("l1_rdata", p == 0 ? b_if_rdata : b_d_rdata, md);
    end

    // randomized traffic against a transaction-level model
    for (int i = 0; i < 16; i++) mref[i] = $urandom;
    e_if = '0; e_d = '0; streak = 0; tx_valid = 1'b0; tx_d = 1'b0; tx_we = 1'b0;
    tx_i = 0; tx_addr = '0; tx_wdata = '0; tx_rdata = '0;
    free_at = cyc;
    for (int n = 0; n < 3000; n++) begin
      int c;
      step();
      c = cyc;
      ack_c   = tx_i + (tx_we ? 2 : L + 2);
      e_en    = tx_valid && (c == tx_i + 1);
      e_ifack = tx_valid && !tx_d && (c == ack_c);
      e_dack  = tx_valid && tx_d && (c == ack_c);
      if ((e_ifack || e_dack) && !tx_we) begin
        if (tx_d) e_d = tx_rdata;
        else      e_if = tx_rdata;
      end
      chk1("rnd_if_ack", if_ack, e_ifack);
      chk1("rnd_d_ack", d_ack, e_dack);
      chk1("rnd_mem_en", mem_en, e_en);
      chk1("rnd_mem_we", mem_we, e_en & tx_we);
      if (e_en) chk("rnd_mem_addr", mem_addr, tx_addr);
      if (e_en && tx_we) chk("rnd_mem_wdata", mem_wdata, tx_wdata);
      chk("rnd_if_rdata", if_rdata, e_if);
      chk("rnd_d_rdata", d_rdata, e_d);
      if (e_ifack || e_dack) tx_valid = 1'b0;

      if (e_ifack) if_req = 1'b0;
      if (e_dack)  d_req = 1'b0;
      if (!if_req && $urandom_range(0, 1) == 0) begin
        idx = 4'($urandom_range(0, 15));
        if_req = 1'b1; if_addr = {26'd0, idx, 2'b00};
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        idx = 4'($urandom_range(0, 15));
        d_req = 1'b1; d_we = $urandom_range(0, 1) == 1;
        d_addr = {26'd0, idx, 2'b00}; d_wdata = $urandom;
      end
      #1;
      chk1("rnd_stall", stall, (if_req & ~e_ifack) | (d_req & ~e_dack));

      if (!tx_valid && c >= free_at && (if_req || d_req)) begin
        tx_d = d_req && !(if_req && streak == MS);
        streak = (tx_d && if_req) ? streak + 1 : 0;
        tx_we    = tx_d & d_we;
        tx_addr  = tx_d ? d_addr : if_addr;
        tx_wdata = d_wdata;
        tx_i     = c;
        tx_valid = 1'b1;
        if (tx_we) mref[tx_addr[5:2]] = tx_wdata;
        tx_rdata = mref[tx_addr[5:2]];
        free_at  = c + (tx_we ? 3 : L + 3);
      end
      mem_rdata = (tx_valid && !tx_we && (c == tx_i + 1 + L)) ? tx_rdata : $urandom;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one memory port between the processor's instruction-fetch requester and its data-access requester, so a single memory array can back both instruction memory and data memory. Each requester uses a level req / pulse ack handshake. The block sequences every access through a fixed-latency memory port and raises `stall` so the datapath holds PC and pipeline state while an access is outstanding. Data accesses have priority, and a streak limit prevents fetch starvation.

## Interface
Parameters:
- `LATENCY`, default 2: memory read latency in cycles, from the `mem_en` cycle to the cycle in which `mem_rdata` is valid. Legal range is 1..15.
- `MAX_STREAK`, default 4: maximum number of consecutive data grants while fetch is waiting. Legal range is 1..15.

Ports (clock and reset first):
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low. 0 forces the reset state immediately.
- `if_req`  in  1: fetch request, held high until `if_ack`.
- `if_addr`  in  32: fetch byte address, stable while `if_req` is high.
- `if_rdata`  out  32: fetched word, valid during `if_ack` and held afterwards.
- `if_ack`  out  1: one-cycle completion pulse for fetch.
- `d_req`  in  1: data request, held high until `d_ack`.
- `d_we`  in  1: 1 = write, 0 = read. Stable while `d_req` is high.
- `d_addr`  in  32: data byte address.
- `d_wdata`  in  32: write data.
- `d_rdata`  out  32: read data, valid during `d_ack` and held afterwards.
- `d_ack`  out  1: one-cycle completion pulse for data.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable. Only ever high together with `mem_en`.
- `mem_addr`  out  32: memory address, passed through unmodified with no alignment check.
- `mem_wdata`  out  32: memory write data.
- `mem_rdata`  in  32: memory read data.
- `stall`  out  1: high when `(if_req & ~if_ack) | (d_req & ~d_ack)`.

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise select a winner:
    - Data wins when both requests are high, unless `streak == MAX_STREAK`, in which case fetch wins.
    - A sole requester always wins.
  - On the grant, register the owner, address, write enable (0 for fetch) and write data.
  - Next state: ACCESS.
- **ACCESS** (exactly one cycle)
  - `mem_en = 1`; `mem_we` = registered write enable.
  - Write: next state RESP.
  - Read: load the wait counter with `LATENCY-1`; next state WAIT.
- **WAIT**
  - Counter nonzero: decrement.
  - Counter zero: capture `mem_rdata` into the owner's rdata register; next state RESP.
- **RESP** (exactly one cycle)
  - Pulse the owner's ack.
  - Next state: IDLE. A req still high during RESP is not re-granted in RESP.
- **Streak counter** (4 bits, saturating at `MAX_STREAK`)
  - Data grant while `if_req` is high: +1.
  - Fetch grant: cleared.
  - Data grant while `if_req` is low: cleared.
- **Write completion:** a write ack leaves `d_rdata` unchanged.
- **Rdata registers:** each port's rdata register changes only when a read for that port completes.
- **Protocol violation:** a requester dropping req before ack does not abort the transaction. The access still completes and the ack still pulses.
- **Reset** (asynchronous, any state, including mid-transaction):
  - State returns to IDLE; streak, counter, rdata registers, acks and `mem_*` outputs all go to 0.
  - The in-flight access is dropped; the requester must re-issue it.
  - `stall` follows its equation, so it is high if any req is high.

## Timing
- Index cycles from I, the IDLE cycle in which the request is sampled and granted.
- Write access: `mem_en` at I+1, ack at I+2, so 3 cycles from request to done.
- Read access: `mem_en` at A = I+1; `mem_rdata` is sampled at the clock edge ending cycle A+LATENCY; ack is at I+LATENCY+2.
- Back-to-back: the next grant happens no earlier than the IDLE cycle following RESP.
  - Read throughput: one transaction per LATENCY+3 cycles.
  - Write throughput: one transaction per 3 cycles.
- `stall` is combinational on req/ack. Every other output is registered or decoded from state only.

## Test plan
- **Reset:** `reset=0` with `if_req=d_req=1` → every output is 0 except `stall=1`. Release reset → the first grant is data, with `mem_en` one cycle after release.
- **Single fetch read:** `LATENCY=2`, `if_addr=0x40`, `mem_rdata=0x8C220004` during cycle A+2 → `if_ack` at I+4 with `if_rdata=0x8C220004`; `d_ack` stays 0 throughout.
- **Data write:** `d_addr=0x100`, `d_wdata=0xDEADBEEF`, `d_we=1` → `mem_en=mem_we=1` at I+1 with the matching address and data; `d_ack` at I+2; `d_rdata` unchanged.
- **Starvation guard:** hold `if_req` high and reissue `d_req` continuously, with `MAX_STREAK=4` → 4 data grants, then 1 fetch grant, and the pattern repeats.
- **Reset mid-read:** assert `reset=0` during WAIT → `mem_en`, both acks and the rdata registers are 0 immediately, and no ack ever appears for the dropped access.
- **LATENCY=1 sweep plus early req drop:** read ack at I+3 with correct data. Separately, drop `d_req` during WAIT → `d_ack` still pulses once.
